hazard_ctrl: RTL and testbench

- Hazard and stall controller for the EV22 pipeline.
- Generates HOLD for UC_1, which converts the issuing instruction into a bubble.
- Consumes UC_1's post-hold outputs (SelC_out, MR_OUT, MW_OUT) to track in-flight destinations in the EX, MEM and WB stages.
- Also runs a memory-wait FSM that freezes the whole pipeline while a load/store in MEM waits on MEM_READY, with a timeout error flag.

---
 rtl/ev22_pipe_pkg.sv | 40 ++++
 rtl/hazard_tag_pipe.sv | 27 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ev22_pipe_pkg.sv
// rtl/ev22_pipe_pkg.sv - shared types, constants and helpers for the EV22 pipeline hazard logic
package ev22_pipe_pkg;

  localparam int SEL_W = 6;
  localparam logic [SEL_W-1:0] NULL_SEL = 6'd35;
  localparam int MEM_TIMEOUT_DEF = 16;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             mr;
    logic             mw;
  } tag_t;

  localparam tag_t NULL_TAG = '{sel: NULL_SEL, mr: 1'b0, mw: 1'b0};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // A stage with no destination (bubble) never matches a source
  function automatic logic sel_match(input logic use_src, input logic [SEL_W-1:0] src,
                                     input tag_t t);
    return use_src && (src == t.sel) && (t.sel != NULL_SEL);
  endfunction

  // Youngest matching stage wins
  function automatic logic [1:0] fwd_code(input logic m_ex, input logic m_mem, input logic m_wb);
    if (m_ex)       return FWD_EX;
    else if (m_mem) return FWD_MEM;
    else if (m_wb)  return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// rtl/hazard_tag_pipe.sv - three-entry freezable tag shift register for EX, MEM and WB
module hazard_tag_pipe
  import ev22_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic freeze,
  input  tag_t issue_tag,
  output tag_t ex_tag,
  output tag_t mem_tag,
  output tag_t wb_tag
);

  // Shift destinations down the pipe unless the whole pipeline is frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag  <= NULL_TAG;
      mem_tag <= NULL_TAG;
      wb_tag  <= NULL_TAG;
    end else if (!freeze) begin
      ex_tag  <= issue_tag;
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - EV22 hazard/stall controller; optional forwarding via EV22_HAZARD_FORWARDING_EN
module hazard_ctrl
  import ev22_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SEL_W-1:0] SelA,
  input  logic             SelA_USE,
  input  logic [SEL_W-1:0] SelB,
  input  logic             SelB_USE,
  input  logic [SEL_W-1:0] SelC_issue,
  input  logic             MR_issue,
  input  logic             MW_issue,
  input  logic             MEM_READY,
  output logic             HOLD,
  output logic             FREEZE,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             MEM_ERR
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  tag_t issue_tag;
  tag_t ex_tag;
  tag_t mem_tag;
  tag_t wb_tag;

  mem_state_t       state;
  mem_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             set_err;
  logic             mem_acc;
  logic             timeout_hit;

  logic ma_ex, ma_mem, ma_wb;
  logic mb_ex, mb_mem, mb_wb;
  logic hold_raw;

  assign issue_tag = '{sel: SelC_issue, mr: MR_issue, mw: MW_issue};

  hazard_tag_pipe u_tags (
    .clk       (CLK),
    .rst       (RST),
    .freeze    (FREEZE),
    .issue_tag (issue_tag),
    .ex_tag    (ex_tag),
    .mem_tag   (mem_tag),
    .wb_tag    (wb_tag)
  );

  // Source-versus-destination matches for every in-flight stage
  always_comb begin
    ma_ex  = sel_match(SelA_USE, SelA, ex_tag);
    ma_mem = sel_match(SelA_USE, SelA, mem_tag);
    ma_wb  = sel_match(SelA_USE, SelA, wb_tag);
    mb_ex  = sel_match(SelB_USE, SelB, ex_tag);
    mb_mem = sel_match(SelB_USE, SelB, mem_tag);
    mb_wb  = sel_match(SelB_USE, SelB, wb_tag);
  end

`ifdef EV22_HAZARD_FORWARDING_EN
  // Forward everything except a load still in EX; that case is a load-use stall
  always_comb begin
    hold_raw = (ma_ex || mb_ex) && ex_tag.mr;
    FWD_A    = fwd_code(ma_ex && !ex_tag.mr, ma_mem, ma_wb);
    FWD_B    = fwd_code(mb_ex && !ex_tag.mr, mb_mem, mb_wb);
  end
`else
  // No bypass network: any in-flight producer stalls decode until it drains
  always_comb begin
    hold_raw = ma_ex || ma_mem || ma_wb || mb_ex || mb_mem || mb_wb;
    FWD_A    = FWD_RF;
    FWD_B    = FWD_RF;
  end
`endif

  assign mem_acc     = mem_tag.mr || mem_tag.mw;
  assign timeout_hit = (state == ST_WAIT) && (cnt == CNT_MAX);
  // On the timeout cycle the access is treated as done, so the pipe moves on
  assign FREEZE      = mem_acc && !MEM_READY && !timeout_hit;
  // A frozen decode slot cannot issue, so a bubble request would be meaningless
  assign HOLD        = hold_raw && !FREEZE;

  // Memory-wait FSM next state, wait counter and timeout detection
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_acc && !MEM_READY) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (MEM_READY) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          set_err   = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state, counter and sticky error register; reset also aborts a pending wait
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      MEM_ERR <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (set_err) MEM_ERR <= 1'b1;
    end
  end

  logic unused_tag_bits;
  assign unused_tag_bits = ^{ex_tag.mr, ex_tag.mw, wb_tag.mr, wb_tag.mw};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;
  import ev22_pipe_pkg::*;

`ifdef EV22_HAZARD_FORWARDING_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif
  localparam logic [5:0] N = 6'd35;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] SelA = N, SelB = N, SelC_issue = N;
  logic       SelA_USE = 1'b0, SelB_USE = 1'b0;
  logic       MR_issue = 1'b0, MW_issue = 1'b0, MEM_READY = 1'b1;
  logic       HOLD, FREEZE, MEM_ERR;
  logic [1:0] FWD_A, FWD_B;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .SelA(SelA), .SelA_USE(SelA_USE), .SelB(SelB), .SelB_USE(SelB_USE),
    .SelC_issue(SelC_issue), .MR_issue(MR_issue), .MW_issue(MW_issue),
    .MEM_READY(MEM_READY),
    .HOLD(HOLD), .FREEZE(FREEZE), .FWD_A(FWD_A), .FWD_B(FWD_B), .MEM_ERR(MEM_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [5:0] sa;
    logic       sau;
    logic [5:0] sb;
    logic       sbu;
    logic [5:0] sc;
    logic       mr;
    logic       chk;
    logic       hold;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic [5:0] sa, logic sau, logic [5:0] sb, logic sbu,
                             logic [5:0] sc, logic mr, logic chk, logic hold,
                             logic [1:0] fa, logic [1:0] fb);
    vec_t r;
    r.rst = rst; r.sa = sa; r.sau = sau; r.sb = sb; r.sbu = sbu;
    r.sc = sc; r.mr = mr; r.chk = chk; r.hold = hold; r.fa = fa; r.fb = fb;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the bench plays UC_1 and bubbles the issue slot when HOLD is expected
  task automatic drive(input logic rst, input logic [5:0] sa, input logic sau,
                       input logic [5:0] sb, input logic sbu, input logic [5:0] sc,
                       input logic mr, input logic mw, input logic rdy, input logic exp_hold);
    @(posedge CLK);
    #1;
    RST = rst; SelA = sa; SelA_USE = sau; SelB = sb; SelB_USE = sbu;
    SelC_issue = exp_hold ? N : sc;
    MR_issue   = exp_hold ? 1'b0 : mr;
    MW_issue   = exp_hold ? 1'b0 : mw;
    MEM_READY  = rdy;
    @(negedge CLK);
  endtask

  task automatic idle_cycle();
    drive(1'b0, N, 1'b0, N, 1'b0, N, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    vecs.push_back(v(1, N, 0, N, 0, N, 0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(v(1, N, 0, N, 0, N, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, N, 0, N, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, N, 0, 6'd5, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, 6'd5, 1, N, 0, N, 0, 1, !F, F ? 2'b01 : 2'b00, 2'b00));
    vecs.push_back(v(0, 6'd5, 1, N, 0, N, 0, 1, !F, F ? 2'b10 : 2'b00, 2'b00));
    vecs.push_back(v(0, 6'd5, 1, N, 0, N, 0, 1, !F, F ? 2'b11 : 2'b00, 2'b00));
    vecs.push_back(v(0, 6'd5, 1, N, 0, N, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, N, 0, 6'd9, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, 6'd9, 0, 6'd9, 0, N, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 1, N, 1, N, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, N, 0, 6'd12, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, N, 0, N, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, 6'd12, 1, N, 0, 1, !F, 2'b00, F ? 2'b10 : 2'b00));
    vecs.push_back(v(0, N, 0, N, 0, 6'd7, 1, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, 6'd7, 1, N, 0, 1, 1, 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, 6'd7, 1, N, 0, 1, !F, 2'b00, F ? 2'b10 : 2'b00));
    vecs.push_back(v(0, N, 0, N, 0, 6'd7, 0, 1, 0, 2'b00, 2'b00));
    vecs.push_back(v(0, 6'd7, 1, 6'd7, 1, 6'd7, 0, 1, !F, F ? 2'b01 : 2'b00, F ? 2'b01 : 2'b00));
    vecs.push_back(v(0, 6'd7, 1, N, 0, N, 0, 1, !F, F ? 2'b01 : 2'b00, 2'b00));
    vecs.push_back(v(0, N, 0, N, 0, N, 0, 1, 0, 2'b00, 2'b00));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sa, vecs[i].sau, vecs[i].sb, vecs[i].sbu,
            vecs[i].sc, vecs[i].mr, 1'b0, 1'b1, vecs[i].hold);
      if (vecs[i].chk) begin
        check($sformatf("v%0d hold", i), HOLD, vecs[i].hold);
        check($sformatf("v%0d fwd_a", i), FWD_A, vecs[i].fa);
        check($sformatf("v%0d fwd_b", i), FWD_B, vecs[i].fb);
        check($sformatf("v%0d freeze", i), FREEZE, 1'b0);
        check($sformatf("v%0d mem_err", i), MEM_ERR, 1'b0);
      end
    end

    // Memory wait: load stalls in MEM for 4 cycles, tags hold, HOLD gated
    idle_cycle();
    idle_cycle();
    drive(1'b0, N, 1'b0, N, 1'b0, 6'd20, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    check("wait pre freeze", FREEZE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 6'd20, 1'b1, N, 1'b0, N, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("wait freeze %0d", i), FREEZE, 1'b1);
      check($sformatf("wait hold gated %0d", i), HOLD, 1'b0);
      check($sformatf("wait mem tag %0d", i), dut.mem_tag.sel, 6'd20);
      check($sformatf("wait mem_err %0d", i), MEM_ERR, 1'b0);
    end
    drive(1'b0, 6'd20, 1'b1, N, 1'b0, N, 1'b0, 1'b0, 1'b1, !F);
    check("wait release freeze", FREEZE, 1'b0);
    check("wait release hold", HOLD, !F);
    idle_cycle();
    check("wait wb tag", dut.wb_tag.sel, 6'd20);

    // Timeout: 16 frozen cycles, then release and sticky error
    idle_cycle();
    drive(1'b0, N, 1'b0, N, 1'b0, 6'd21, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, N, 1'b0, N, 1'b0, N, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("tmo freeze %0d", i), FREEZE, 1'b1);
    end
    drive(1'b0, N, 1'b0, N, 1'b0, N, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tmo release freeze", FREEZE, 1'b0);
    check("tmo err not yet", MEM_ERR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, N, 1'b0, N, 1'b0, N, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("tmo err sticky %0d", i), MEM_ERR, 1'b1);
      check($sformatf("tmo after freeze %0d", i), FREEZE, 1'b0);
    end

    // Reset mid-wait: store waits, RST at cnt=3 aborts without error
    drive(1'b0, N, 1'b0, N, 1'b0, 6'd22, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, N, 1'b0, N, 1'b0, N, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("rst wait freeze %0d", i), FREEZE, 1'b1);
    end
    drive(1'b1, N, 1'b0, N, 1'b0, N, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst cycle freeze", FREEZE, 1'b1);
    check("rst cycle err", MEM_ERR, 1'b1);
    drive(1'b0, N, 1'b0, N, 1'b0, N, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post rst freeze", FREEZE, 1'b0);
    check("post rst err", MEM_ERR, 1'b0);
    check("post rst ex tag", dut.ex_tag.sel, N);
    check("post rst mem tag", dut.mem_tag.sel, N);
    check("post rst wb tag", dut.wb_tag.sel, N);
    check("post rst mem mw", dut.mem_tag.mw, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
